// File: rtl/ahb_split_slave.sv
`default_nettype none
// ============================================================================
// ahb_split_slave
// AHB register-file slave that issues SPLIT, RETRY and ERROR responses.
// Rev 1.0
// ============================================================================
module ahb_split_slave #(
  parameter int MEM_WORDS     = 16,
  parameter int SPLIT_LATENCY = 4,
  parameter int SLOW_BIT      = 11
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic [3:0]  HMASTER,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic [15:0] HSPLIT
);

  localparam int          IW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [1:0]  C_OKAY   = 2'b00;
  localparam logic [1:0]  C_ERROR  = 2'b01;
  localparam logic [1:0]  C_RETRY  = 2'b10;
  localparam logic [1:0]  C_SPLIT  = 2'b11;
  localparam logic [7:0]  C_LAT_M1 = 8'(SPLIT_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP1, S_RESP2} state_t;
  typedef enum logic [1:0] {T_NONE, T_COUNT, T_READY} trk_t;

  state_t          state_q, state_d;
  logic [1:0]      code_q, code_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            dph_rd_q, dph_rd_d;
  logic            dph_wr_q, dph_wr_d;
  trk_t            trk_q, trk_d;
  logic [3:0]      trk_mst_q, trk_mst_d;
  logic [IW-1:0]   trk_idx_q, trk_idx_d;
  logic            armed_q, armed_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     mem_q [MEM_WORDS];

  logic            w_ready;
  logic            w_accept;
  logic [IW-1:0]   w_idx;
  logic            w_slow;
  logic            w_pulse;
  logic            w_unused;

  assign w_ready  = (state_q != S_WAIT) && (state_q != S_RESP1);
  assign w_accept = HSEL && HREADY && HTRANS[1] && w_ready;
  assign w_idx    = HADDR[IW+1:2];
  assign w_slow   = HADDR[SLOW_BIT];
  assign w_pulse  = (trk_q == T_COUNT) && armed_q && (cnt_q == 8'd0);
  assign w_unused = ^{HADDR[31:IW+2], HADDR[1:0], HTRANS[0]};

  assign HREADYOUT = w_ready;
  assign HRESP     = ((state_q == S_RESP1) || (state_q == S_RESP2)) ? code_q : C_OKAY;
  assign HRDATA    = ((state_q == S_IDLE) && dph_rd_q) ? mem_q[idx_q] : 32'd0;
  assign HSPLIT    = w_pulse ? (16'd1 << trk_mst_q) : 16'd0;

  always_comb begin
    state_d   = S_IDLE;
    code_d    = code_q;
    idx_d     = idx_q;
    dph_rd_d  = 1'b0;
    dph_wr_d  = 1'b0;
    trk_d     = trk_q;
    trk_mst_d = trk_mst_q;
    trk_idx_d = trk_idx_q;
    armed_d   = armed_q;
    cnt_d     = cnt_q;

    if (state_q == S_WAIT) begin
      dph_rd_d = dph_rd_q;
    end else if (state_q == S_RESP1) begin
      state_d = S_RESP2;
    end

    // Countdown starts only once the SPLIT response has fully completed
    if ((state_q == S_RESP2) && (code_q == C_SPLIT)) begin
      armed_d = 1'b1;
      cnt_d   = C_LAT_M1;
    end else if ((trk_q == T_COUNT) && armed_q) begin
      if (cnt_q == 8'd0) begin
        trk_d   = T_READY;
        armed_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end

    if (w_accept) begin
      idx_d = w_idx;
      if (HSIZE != 3'b010) begin
        state_d = S_RESP1;
        code_d  = C_ERROR;
      end else if (HWRITE) begin
        dph_wr_d = 1'b1;
      end else if (!w_slow) begin
        dph_rd_d = 1'b1;
      end else if (HMASTLOCK) begin
        state_d  = S_WAIT;
        dph_rd_d = 1'b1;
      end else if (trk_q == T_NONE) begin
        state_d   = S_RESP1;
        code_d    = C_SPLIT;
        trk_d     = T_COUNT;
        trk_mst_d = HMASTER;
        trk_idx_d = w_idx;
        armed_d   = 1'b0;
      end else if ((trk_q == T_READY) && (trk_mst_q == HMASTER) && (trk_idx_q == w_idx)) begin
        dph_rd_d = 1'b1;
        trk_d    = T_NONE;
      end else begin
        state_d = S_RESP1;
        code_d  = C_RETRY;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      code_q    <= C_OKAY;
      idx_q     <= '0;
      dph_rd_q  <= 1'b0;
      dph_wr_q  <= 1'b0;
      trk_q     <= T_NONE;
      trk_mst_q <= 4'd0;
      trk_idx_q <= '0;
      armed_q   <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      idx_q     <= idx_d;
      dph_rd_q  <= dph_rd_d;
      dph_wr_q  <= dph_wr_d;
      trk_q     <= trk_d;
      trk_mst_q <= trk_mst_d;
      trk_idx_q <= trk_idx_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (dph_wr_q) begin
      mem_q[idx_q] <= HWDATA;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_split_slave.sv
`default_nettype none
// ============================================================================
// tb_ahb_split_slave
// Directed self-checking bench for ahb_split_slave.
// Rev 1.0
// ============================================================================
module tb_ahb_split_slave;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [3:0]  HMASTER;
  logic        HMASTLOCK;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [15:0] HSPLIT;

  int vecs = 0;
  int errs = 0;

  ahb_split_slave #(
    .MEM_WORDS    (16),
    .SPLIT_LATENCY(4),
    .SLOW_BIT     (11)
  ) u_dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK),
    .HREADY    (HREADYOUT),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .HSPLIT    (HSPLIT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic rdy, input logic [1:0] resp, input logic [15:0] spl);
    chk({tag, ".hreadyout"}, {31'd0, HREADYOUT}, {31'd0, rdy});
    chk({tag, ".hresp"},     {30'd0, HRESP},     {30'd0, resp});
    chk({tag, ".hsplit"},    {16'd0, HSPLIT},    {16'd0, spl});
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [3:0] m, input logic lk);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w;
    HSIZE = sz; HMASTER = m; HMASTLOCK = lk;
  endtask

  task automatic idle_bus();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HMASTLOCK = 1'b0;
  endtask

  task automatic nxt();
    @(negedge HCLK);
  endtask

  initial begin
    HRESET = 1'b1; HADDR = 32'd0; HSIZE = 3'b010; HWDATA = 32'd0; HMASTER = 4'd0;
    idle_bus();
    nxt(); nxt();
    chk_bus("reset", 1'b1, 2'b00, 16'h0000);
    chk("reset.hrdata", HRDATA, 32'd0);
    HRESET = 1'b0;

    // Write then read back a fast word
    nxt(); drive(32'h004, 1'b1, 3'b010, 4'd1, 1'b0);
    nxt(); chk_bus("wr004", 1'b1, 2'b00, 16'h0);
    HWDATA = 32'hDEADBEEF; drive(32'h004, 1'b0, 3'b010, 4'd1, 1'b0);
    nxt(); chk_bus("rd004", 1'b1, 2'b00, 16'h0);
    chk("rd004.hrdata", HRDATA, 32'hDEADBEEF);
    drive(32'h810, 1'b1, 3'b010, 4'd1, 1'b0);
    nxt(); HWDATA = 32'h0000_0810; idle_bus();

    // Byte-size read gives a two-cycle ERROR, then a word read is zero-wait
    nxt(); drive(32'h004, 1'b0, 3'b000, 4'd1, 1'b0);
    nxt(); chk_bus("err.c1", 1'b0, 2'b01, 16'h0); idle_bus();
    nxt(); chk_bus("err.c2", 1'b1, 2'b01, 16'h0);
    drive(32'h004, 1'b0, 3'b010, 4'd1, 1'b0);
    nxt(); chk_bus("err.next", 1'b1, 2'b00, 16'h0);
    chk("err.next.hrdata", HRDATA, 32'hDEADBEEF);
    idle_bus();

    // Locked slow read: one wait state, never split
    nxt(); drive(32'h810, 1'b0, 3'b010, 4'd2, 1'b1);
    nxt(); chk_bus("lock.wait", 1'b0, 2'b00, 16'h0); idle_bus();
    nxt(); chk_bus("lock.data", 1'b1, 2'b00, 16'h0);
    chk("lock.hrdata", HRDATA, 32'h0000_0810);

    // Master 3 split, master 5 retried while counting, write to split index
    nxt(); drive(32'h804, 1'b0, 3'b010, 4'd3, 1'b0);
    nxt(); chk_bus("split.c1", 1'b0, 2'b11, 16'h0); idle_bus();
    nxt(); chk_bus("split.c2", 1'b1, 2'b11, 16'h0);
    drive(32'h808, 1'b0, 3'b010, 4'd5, 1'b0);
    nxt(); chk_bus("retry5.c1", 1'b0, 2'b10, 16'h0); idle_bus();
    nxt(); chk_bus("retry5.c2", 1'b1, 2'b10, 16'h0);
    drive(32'h004, 1'b1, 3'b010, 4'd1, 1'b0);
    nxt(); chk_bus("cnt.wr", 1'b1, 2'b00, 16'h0);
    HWDATA = 32'hCAFEF00D; idle_bus();
    nxt(); chk_bus("hsplit.pulse", 1'b1, 2'b00, 16'h0008);
    nxt(); chk_bus("hsplit.after", 1'b1, 2'b00, 16'h0);

    // Tracker READY: wrong master and wrong index are retried
    drive(32'h804, 1'b0, 3'b010, 4'd5, 1'b0);
    nxt(); chk_bus("rdy.m5.c1", 1'b0, 2'b10, 16'h0); idle_bus();
    nxt(); chk_bus("rdy.m5.c2", 1'b1, 2'b10, 16'h0);
    drive(32'h808, 1'b0, 3'b010, 4'd3, 1'b0);
    nxt(); chk_bus("rdy.idx.c1", 1'b0, 2'b10, 16'h0); idle_bus();
    nxt(); chk_bus("rdy.idx.c2", 1'b1, 2'b10, 16'h0);
    drive(32'h804, 1'b0, 3'b010, 4'd3, 1'b0);
    nxt(); chk_bus("resume", 1'b1, 2'b00, 16'h0);
    chk("resume.hrdata", HRDATA, 32'hCAFEF00D);

    // Tracker back to NONE: new split accepted, then reset mid-RESP1
    drive(32'h80C, 1'b0, 3'b010, 4'd4, 1'b0);
    nxt(); chk_bus("split4.c1", 1'b0, 2'b11, 16'h0); idle_bus();
    HRESET = 1'b1;
    #1 chk_bus("rst.mid", 1'b1, 2'b00, 16'h0);
    nxt(); HRESET = 1'b0;

    drive(32'h004, 1'b0, 3'b010, 4'd1, 1'b0);
    nxt(); chk("rst.mem", HRDATA, 32'd0);
    drive(32'h804, 1'b0, 3'b010, 4'd6, 1'b0);
    nxt(); chk_bus("split6.c1", 1'b0, 2'b11, 16'h0); idle_bus();
    nxt(); chk_bus("split6.c2", 1'b1, 2'b11, 16'h0);
    nxt(); chk_bus("split6.t1", 1'b1, 2'b00, 16'h0);
    nxt(); chk_bus("split6.t2", 1'b1, 2'b00, 16'h0);
    nxt(); chk_bus("split6.t3", 1'b1, 2'b00, 16'h0);
    nxt(); chk_bus("split6.t4", 1'b1, 2'b00, 16'h0040);
    nxt(); chk_bus("split6.t5", 1'b1, 2'b00, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
